if_id_queue: RTL and testbench

//  Parametrised fetch->decode instruction queue; successor of the single-entry IF/ID register.

---
 rtl/if_id_queue_if.sv | 30 +++
 rtl/if_id_queue.sv | 80 ++++++++
 tb/tb_if_id_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch->decode queue interface: fetch push side, decode pop side, flush and occupancy.
// slave is the queue itself; master is whoever drives fetch and decode.
interface if_id_queue_if #(
   parameter int XLEN  = 32,
   parameter int ILEN  = 32,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            in_valid;
   logic            in_ready;
   logic [ILEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [ILEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [CW-1:0]   count;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc, count
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, count
   );
endinterface

// File: rtl/if_id_queue.sv
// Fetch->decode instruction queue: DEPTH-entry circular buffer of {instr, pc}.
// Outputs come from registered state only; decode sees NOP_INSN/pc 0 while empty.
module if_id_queue #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [ILEN-1:0] NOP_INSN = 32'h00000013
) (
   input logic          clock,
   input logic          resetn,
   if_id_queue_if.slave q
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [ILEN-1:0] mem_instr [DEPTH];
   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic            valid;
   logic            ready;
   logic            push;
   logic            pop;

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready depends only on occupancy, never on out_ready, so a full queue refuses
   // a push even in a cycle where decode pops.
   assign valid = (count_q != '0);
   assign ready = (count_q != FULL);
   assign push  = q.in_valid & ready;
   assign pop   = valid & q.out_ready;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (q.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage is deliberately left out of reset; entries are qualified by count.
   always_ff @(posedge clock) begin
      if (push && !q.flush) begin
         mem_instr[wr_ptr] <= q.in_instr;
         mem_pc[wr_ptr]    <= q.in_pc;
      end
   end

   assign q.in_ready  = ready;
   assign q.out_valid = valid;
   assign q.out_instr = valid ? mem_instr[rd_ptr] : NOP_INSN;
   assign q.out_pc    = valid ? mem_pc[rd_ptr] : '0;
   assign q.count     = count_q;

   a_count_max: assert property (@(posedge clock) disable iff (!resetn)
      count_q <= FULL);
   a_out_valid: assert property (@(posedge clock) disable iff (!resetn)
      q.out_valid == (count_q != '0));
   a_in_ready: assert property (@(posedge clock) disable iff (!resetn)
      q.in_ready == (count_q != FULL));
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: three instances (DEPTH 2, 4, 3) sharing clock and reset.
module tb_if_id_queue;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clock;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   if_id_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(2)) q2 ();
   if_id_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) q4 ();
   if_id_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(3)) q3 ();

   if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(2)) u2 (.clock(clock), .resetn(resetn), .q(q2.slave));
   if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(4)) u4 (.clock(clock), .resetn(resetn), .q(q4.slave));
   if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(3)) u3 (.clock(clock), .resetn(resetn), .q(q3.slave));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hA000_0000 | pc;
   endfunction

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_all;
      q2.in_valid = 0; q2.in_instr = 0; q2.in_pc = 0; q2.flush = 0; q2.out_ready = 0;
      q4.in_valid = 0; q4.in_instr = 0; q4.in_pc = 0; q4.flush = 0; q4.out_ready = 0;
      q3.in_valid = 0; q3.in_instr = 0; q3.in_pc = 0; q3.flush = 0; q3.out_ready = 0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      idle_all();
      repeat (2) step();
      checks++; if (q2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", q2.out_valid); end
      checks++; if (q2.out_instr !== NOP) begin errors++; $display("FAIL reset_out_instr: got %h expected %h", q2.out_instr, NOP); end
      checks++; if (q2.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", q2.out_pc); end
      checks++; if (q2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", q2.in_ready); end
      checks++; if (q4.count !== 3'd0 || q3.count !== 2'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", q4.count, q3.count); end
      resetn = 1'b1;
      step();
      // fill d2 then pull reset between clock edges
      q2.in_valid = 1; q2.in_pc = 32'h40; q2.in_instr = instr_of(32'h40);
      step();
      q2.in_pc = 32'h44; q2.in_instr = instr_of(32'h44);
      step();
      q2.in_valid = 0;
      checks++; if (q2.count !== 2'd2) begin errors++; $display("FAIL prereset_count: got %0d expected 2", q2.count); end
      #3 resetn = 1'b0;
      #1;
      checks++; if (q2.count !== 2'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", q2.count); end
      checks++; if (q2.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid: got %b expected 0", q2.out_valid); end
      checks++; if (q2.out_instr !== NOP || q2.out_pc !== 32'h0) begin errors++; $display("FAIL async_reset_outputs: got %h/%h expected %h/0", q2.out_instr, q2.out_pc, NOP); end
      checks++; if (q2.in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b expected 1", q2.in_ready); end
      step();
      #2 resetn = 1'b1;
      step();
      checks++; if (q2.out_valid !== 1'b0 || q2.count !== 2'd0) begin errors++; $display("FAIL post_reset_empty: got valid %b count %0d expected 0 0", q2.out_valid, q2.count); end
   endtask

   task automatic test_pass_through;
      logic [31:0] pc;
      q2.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         pc = 32'(4 * i);
         q2.in_valid = 1; q2.in_pc = pc; q2.in_instr = instr_of(pc);
         step();
         checks++; if (q2.out_valid !== 1'b1 || q2.out_pc !== pc || q2.out_instr !== instr_of(pc)) begin
            errors++; $display("FAIL pass_head_%0d: got v%b pc %h instr %h expected v1 pc %h instr %h", i, q2.out_valid, q2.out_pc, q2.out_instr, pc, instr_of(pc)); end
         checks++; if (q2.count !== 2'd1) begin errors++; $display("FAIL pass_count_%0d: got %0d expected 1", i, q2.count); end
      end
      q2.in_valid = 0;
      step();
      checks++; if (q2.out_valid !== 1'b0 || q2.out_instr !== NOP || q2.count !== 2'd0) begin
         errors++; $display("FAIL pass_drain: got v%b instr %h count %0d expected v0 instr %h count 0", q2.out_valid, q2.out_instr, q2.count, NOP); end
      q2.out_ready = 0;
   endtask

   task automatic test_fill_stall;
      logic [31:0] pc;
      q4.out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         pc = 32'(4 * i);
         q4.in_valid = 1; q4.in_pc = pc; q4.in_instr = instr_of(pc);
         step();
         checks++; if (q4.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, q4.count, i + 1); end
      end
      checks++; if (q4.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", q4.in_ready); end
      q4.in_pc = 32'h10; q4.in_instr = instr_of(32'h10);
      repeat (2) begin
         step();
         checks++; if (q4.count !== 3'd4 || q4.out_pc !== 32'h0 || q4.out_instr !== instr_of(32'h0)) begin
            errors++; $display("FAIL stall_hold: got count %0d pc %h instr %h expected 4 0 %h", q4.count, q4.out_pc, q4.out_instr, instr_of(32'h0)); end
      end
      q4.out_ready = 1;
      step();
      checks++; if (q4.count !== 3'd3 || q4.out_pc !== 32'h4) begin errors++; $display("FAIL drain_first: got count %0d pc %h expected 3 4", q4.count, q4.out_pc); end
      step();
      checks++; if (q4.count !== 3'd3 || q4.out_pc !== 32'h8) begin errors++; $display("FAIL held_accept: got count %0d pc %h expected 3 8", q4.count, q4.out_pc); end
      q4.in_valid = 0;
      step();
      checks++; if (q4.out_pc !== 32'hC || q4.count !== 3'd2) begin errors++; $display("FAIL drain_c: got pc %h count %0d expected c 2", q4.out_pc, q4.count); end
      step();
      checks++; if (q4.out_pc !== 32'h10 || q4.out_instr !== instr_of(32'h10) || q4.count !== 3'd1) begin
         errors++; $display("FAIL drain_held: got pc %h count %0d expected 10 1", q4.out_pc, q4.count); end
      step();
      checks++; if (q4.out_valid !== 1'b0 || q4.out_pc !== 32'h0) begin errors++; $display("FAIL drain_empty: got v%b pc %h expected v0 0", q4.out_valid, q4.out_pc); end
      q4.out_ready = 0;
   endtask

   task automatic test_wrap;
      logic [31:0] exp_q[$];
      logic [31:0] head;
      int pushed = 0;
      int popped = 0;
      int cyc    = 0;
      while ((pushed < 10 || popped < 10) && cyc < 300) begin
         q3.in_valid  = (pushed < 10);
         q3.in_pc     = 32'h500 + 32'(4 * pushed);
         q3.in_instr  = instr_of(q3.in_pc);
         q3.out_ready = 1'($urandom_range(0, 1));
         #1;
         checks++; if (q3.out_valid !== (exp_q.size() != 0) || q3.in_ready !== (exp_q.size() != 3)) begin
            errors++; $display("FAIL wrap_flags: got v%b r%b expected size %0d", q3.out_valid, q3.in_ready, exp_q.size()); end
         if (q3.out_valid && q3.out_ready && exp_q.size() != 0) begin
            head = exp_q.pop_front();
            checks++; if (q3.out_pc !== head || q3.out_instr !== instr_of(head)) begin
               errors++; $display("FAIL wrap_order_%0d: got pc %h instr %h expected pc %h", popped, q3.out_pc, q3.out_instr, head); end
            popped++;
         end
         if (q3.in_valid && q3.in_ready) begin
            exp_q.push_back(q3.in_pc);
            pushed++;
         end
         step();
         cyc++;
         checks++; if (int'(q3.count) !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", q3.count, exp_q.size()); end
      end
      checks++; if (cyc >= 300) begin errors++; $display("FAIL wrap_timeout: got %0d pushed %0d popped expected 10 10", pushed, popped); end
      q3.in_valid = 0; q3.out_ready = 0;
   endtask

   task automatic test_flush;
      logic [31:0] pc;
      q4.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         pc = 32'h100 + 32'(4 * i);
         q4.in_valid = 1; q4.in_pc = pc; q4.in_instr = instr_of(pc);
         step();
      end
      checks++; if (q4.count !== 3'd3 || q4.out_pc !== 32'h100) begin errors++; $display("FAIL preflush: got count %0d pc %h expected 3 100", q4.count, q4.out_pc); end
      q4.in_pc = 32'h10C; q4.in_instr = instr_of(32'h10C);
      q4.out_ready = 1; q4.flush = 1;
      step();
      q4.flush = 0; q4.in_valid = 0;
      checks++; if (q4.count !== 3'd0 || q4.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got count %0d v%b expected 0 v0", q4.count, q4.out_valid); end
      checks++; if (q4.out_instr !== NOP || q4.out_pc !== 32'h0 || q4.in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_outputs: got instr %h pc %h r%b expected %h 0 r1", q4.out_instr, q4.out_pc, q4.in_ready, NOP); end
      step();
      checks++; if (q4.out_valid !== 1'b0 || q4.count !== 3'd0) begin errors++; $display("FAIL flush_no_ghost: got v%b count %0d expected v0 0", q4.out_valid, q4.count); end
      q4.in_valid = 1; q4.in_pc = 32'h200; q4.in_instr = instr_of(32'h200); q4.out_ready = 0;
      step();
      q4.in_valid = 0;
      checks++; if (q4.out_pc !== 32'h200 || q4.count !== 3'd1) begin errors++; $display("FAIL after_flush_push: got pc %h count %0d expected 200 1", q4.out_pc, q4.count); end
      q4.out_ready = 1;
      step();
      q4.out_ready = 0;
   endtask

   task automatic test_full_pop;
      q2.out_ready = 0;
      q2.in_valid = 1; q2.in_pc = 32'h300; q2.in_instr = instr_of(32'h300);
      step();
      q2.in_pc = 32'h304; q2.in_instr = instr_of(32'h304);
      step();
      checks++; if (q2.count !== 2'd2 || q2.in_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count %0d r%b expected 2 r0", q2.count, q2.in_ready); end
      q2.in_pc = 32'h308; q2.in_instr = instr_of(32'h308); q2.out_ready = 1;
      step();
      q2.in_valid = 0;
      checks++; if (q2.count !== 2'd1 || q2.out_pc !== 32'h304) begin errors++; $display("FAIL full_pop_only: got count %0d pc %h expected 1 304", q2.count, q2.out_pc); end
      step();
      checks++; if (q2.count !== 2'd0 || q2.out_valid !== 1'b0) begin errors++; $display("FAIL full_push_dropped: got count %0d v%b expected 0 v0", q2.count, q2.out_valid); end
      q2.out_ready = 0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_fill_stall();
      test_wrap();
      test_flush();
      test_full_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
